// File: rtl/fp_pkg.sv
// Shared floating-point converter definitions: IEEE-754 single field constants
// and the state encoding common to the float/int converters.
package fp_pkg;

  localparam int          EXP_BIAS  = 127;
  localparam logic [7:0]  EXP_MAX   = 8'hFF;
  localparam int          MANT_W    = 23;
  localparam logic [31:0] INT_MIN_F = 32'hCF000000;

  typedef enum logic [2:0] {
    GET_A  = 3'd0,
    UNPACK = 3'd1,
    RANGE  = 3'd2,
    SHIFT  = 3'd3,
    PACK   = 3'd4,
    PUT_Z  = 3'd5
  } cvt_state_e;

endpackage

// File: rtl/float_to_int.sv
// IEEE-754 single to signed 32-bit integer, truncating toward zero.
// Iterative one-bit shifter; stb/ack stream handshake on both sides.
module float_to_int
  import fp_pkg::*;
#(
  parameter logic [31:0] INVALID_VALUE = 32'h80000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] input_a,
  input  logic        input_a_stb,
  output logic        input_a_ack,
  output logic [31:0] output_z,
  output logic        output_z_invalid,
  output logic        output_z_stb,
  input  logic        output_z_ack
);

  cvt_state_e         state_q, state_d;
  logic [31:0]        a_q, a_d;
  logic               s_q, s_d;
  logic signed [9:0]  e_q, e_d;
  logic [MANT_W:0]    m_q, m_d;
  logic [31:0]        z_q, z_d;
  logic               invalid_q, invalid_d;
  logic               in_ack_q, in_ack_d;
  logic               out_stb_q, out_stb_d;
  logic [31:0]        out_z_q, out_z_d;
  logic               out_inv_q, out_inv_d;

  logic [7:0] exp_field;
  assign exp_field = a_q[30:23];

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    s_d       = s_q;
    e_d       = e_q;
    m_d       = m_q;
    z_d       = z_q;
    invalid_d = invalid_q;
    in_ack_d  = in_ack_q;
    out_stb_d = out_stb_q;
    out_z_d   = out_z_q;
    out_inv_d = out_inv_q;
    case (state_q)
      GET_A: begin
        in_ack_d = 1'b1;
        if (in_ack_q && input_a_stb) begin
          a_d      = input_a;
          in_ack_d = 1'b0;
          state_d  = UNPACK;
        end
      end
      UNPACK: begin
        s_d     = a_q[31];
        e_d     = $signed({2'b00, a_q[30:23]}) - 10'sd127;
        m_d     = {1'b1, a_q[22:0]};
        state_d = RANGE;
      end
      RANGE: begin
        invalid_d = 1'b0;
        // Zero results park in SHIFT with e already at 31 so they take the
        // single exit cycle; specials go through PACK, where the sign is ignored.
        if (exp_field == 8'd0 || e_q < 10'sd0) begin
          z_d     = '0;
          e_d     = 10'sd31;
          state_d = SHIFT;
        end else if (exp_field == EXP_MAX) begin
          z_d       = INVALID_VALUE;
          invalid_d = 1'b1;
          state_d   = PACK;
        end else if (a_q == INT_MIN_F) begin
          z_d     = 32'h80000000;
          s_d     = 1'b0;
          state_d = PACK;
        end else if (e_q >= 10'sd31) begin
          z_d       = INVALID_VALUE;
          invalid_d = 1'b1;
          state_d   = PACK;
        end else begin
          z_d     = {m_q, 8'b0};
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (e_q < 10'sd31) begin
          z_d = z_q >> 1;
          e_d = e_q + 10'sd1;
        end else begin
          state_d = PACK;
        end
      end
      PACK: begin
        z_d     = (s_q && !invalid_q) ? -z_q : z_q;
        state_d = PUT_Z;
      end
      PUT_Z: begin
        out_z_d   = z_q;
        out_inv_d = invalid_q;
        out_stb_d = 1'b1;
        if (out_stb_q && output_z_ack) begin
          out_stb_d = 1'b0;
          state_d   = GET_A;
        end
      end
      default: state_d = GET_A;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= GET_A;
      a_q       <= '0;
      s_q       <= 1'b0;
      e_q       <= '0;
      m_q       <= '0;
      z_q       <= '0;
      invalid_q <= 1'b0;
      in_ack_q  <= 1'b0;
      out_stb_q <= 1'b0;
      out_z_q   <= '0;
      out_inv_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      s_q       <= s_d;
      e_q       <= e_d;
      m_q       <= m_d;
      z_q       <= z_d;
      invalid_q <= invalid_d;
      in_ack_q  <= in_ack_d;
      out_stb_q <= out_stb_d;
      out_z_q   <= out_z_d;
      out_inv_q <= out_inv_d;
    end
  end

  assign input_a_ack      = in_ack_q;
  assign output_z_stb     = out_stb_q;
  assign output_z         = out_z_q;
  assign output_z_invalid = out_inv_q;

endmodule

// File: tb/tb_float_to_int.sv
// Directed-vector bench for float_to_int: values, invalid flag, latency,
// back-pressure and mid-conversion reset.
module tb_float_to_int;

  logic        clk;
  logic        rst;
  logic [31:0] input_a;
  logic        input_a_stb;
  logic        input_a_ack;
  logic [31:0] output_z;
  logic        output_z_invalid;
  logic        output_z_stb;
  logic        output_z_ack;

  int checks;
  int errors;

  float_to_int dut (
    .clk              (clk),
    .rst              (rst),
    .input_a          (input_a),
    .input_a_stb      (input_a_stb),
    .input_a_ack      (input_a_ack),
    .output_z         (output_z),
    .output_z_invalid (output_z_invalid),
    .output_z_stb     (output_z_stb),
    .output_z_ack     (output_z_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Offer an operand and return once the capture edge has passed.
  task automatic capture(input logic [31:0] a, output bit ok);
    int n;
    ok = 1'b1;
    input_a     = a;
    input_a_stb = 1'b1;
    n = 0;
    while (!input_a_ack && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!input_a_ack) begin
      ok = 1'b0;
      checks++;
      errors++;
      $display("FAIL capture_timeout a=%h: input_a_ack never rose", a);
    end else begin
      @(posedge clk);
    end
    #1 input_a_stb = 1'b0;
  endtask

  // Capture then count edges until output_z_stb is high; result left pending.
  task automatic start_and_wait(input logic [31:0] a, output int lat, output bit ok);
    capture(a, ok);
    lat = 0;
    if (ok) begin
      checks++;
      if (input_a_ack !== 1'b0) begin
        errors++;
        $display("FAIL ack_drop a=%h: input_a_ack=%b required 0", a, input_a_ack);
      end
      while (!output_z_stb && lat < 100) begin
        @(posedge clk);
        #1 lat++;
      end
      if (!output_z_stb) begin
        ok = 1'b0;
        checks++;
        errors++;
        $display("FAIL result_timeout a=%h: output_z_stb never rose", a);
      end
    end
  endtask

  task automatic ack_result();
    output_z_ack = 1'b1;
    @(posedge clk);
    #1 output_z_ack = 1'b0;
  endtask

  task automatic run(input logic [31:0] a, output logic [31:0] z, output logic inv,
                     output int lat, output bit ok);
    start_and_wait(a, lat, ok);
    z   = output_z;
    inv = output_z_invalid;
    if (ok) begin
      ack_result();
      checks++;
      if (output_z_stb !== 1'b0) begin
        errors++;
        $display("FAIL stb_drop a=%h: output_z_stb=%b required 0", a, output_z_stb);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (output_z_stb !== 1'b0) begin errors++; $display("FAIL reset_stb: got %b want 0", output_z_stb); end
    checks++;
    if (input_a_ack !== 1'b0) begin errors++; $display("FAIL reset_in_ack: got %b want 0", input_a_ack); end
    checks++;
    if (output_z !== 32'h0) begin errors++; $display("FAIL reset_z: got %h want 00000000", output_z); end
    checks++;
    if (output_z_invalid !== 1'b0) begin errors++; $display("FAIL reset_inv: got %b want 0", output_z_invalid); end
    @(negedge clk) rst = 1'b1;
  endtask

  // Table of {operand, result, invalid, latency}; latency 36-e for normals.
  task automatic test_vectors();
    logic [31:0] va [13];
    logic [31:0] vz [13];
    logic        vi [13];
    int          vl [13];
    logic [31:0] z;
    logic        inv;
    int          lat;
    bit          ok;
    va[0]  = 32'h3F800000; vz[0]  = 32'h00000001; vi[0]  = 0; vl[0]  = 36; //  1.0
    va[1]  = 32'hC0200000; vz[1]  = 32'hFFFFFFFE; vi[1]  = 0; vl[1]  = 35; // -2.5
    va[2]  = 32'h3F400000; vz[2]  = 32'h00000000; vi[2]  = 0; vl[2]  = 5;  //  0.75
    va[3]  = 32'h42F6E979; vz[3]  = 32'h0000007B; vi[3]  = 0; vl[3]  = 30; //  123.456
    va[4]  = 32'h4EFFFFFF; vz[4]  = 32'h7FFFFF80; vi[4]  = 0; vl[4]  = 6;
    va[5]  = 32'h80000000; vz[5]  = 32'h00000000; vi[5]  = 0; vl[5]  = 5;  // -0.0
    va[6]  = 32'h00000001; vz[6]  = 32'h00000000; vi[6]  = 0; vl[6]  = 5;  // denormal
    va[7]  = 32'h4F000000; vz[7]  = 32'h80000000; vi[7]  = 1; vl[7]  = 4;  //  2^31
    va[8]  = 32'hCF000000; vz[8]  = 32'h80000000; vi[8]  = 0; vl[8]  = 4;  // -2^31
    va[9]  = 32'h7FC00000; vz[9]  = 32'h80000000; vi[9]  = 1; vl[9]  = 4;  // NaN
    va[10] = 32'hFF800000; vz[10] = 32'h80000000; vi[10] = 1; vl[10] = 4;  // -Inf
    va[11] = 32'hCF000001; vz[11] = 32'h80000000; vi[11] = 1; vl[11] = 4;  // just below -2^31
    va[12] = 32'hC2F6E979; vz[12] = 32'hFFFFFF85; vi[12] = 0; vl[12] = 30; // -123.456
    for (int i = 0; i < 13; i++) begin
      run(va[i], z, inv, lat, ok);
      if (ok) begin
        checks++;
        if (z !== vz[i]) begin
          errors++;
          $display("FAIL value a=%h: got %h want %h", va[i], z, vz[i]);
        end
        checks++;
        if (inv !== vi[i]) begin
          errors++;
          $display("FAIL invalid a=%h: got %b want %b", va[i], inv, vi[i]);
        end
        checks++;
        if (lat != vl[i]) begin
          errors++;
          $display("FAIL latency a=%h: got %0d want %0d", va[i], lat, vl[i]);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    int lat;
    bit ok;
    logic [31:0] z;
    logic        inv;
    start_and_wait(32'hC0200000, lat, ok);
    if (ok) begin
      // A competing operand and a stray ack-free hold must not disturb the result.
      input_a     = 32'h3F800000;
      input_a_stb = 1'b1;
      for (int c = 0; c < 10; c++) begin
        @(posedge clk);
        #1;
        checks++;
        if (output_z_stb !== 1'b1 || output_z !== 32'hFFFFFFFE || output_z_invalid !== 1'b0) begin
          errors++;
          $display("FAIL hold_stable cycle %0d: stb=%b z=%h inv=%b want 1 fffffffe 0",
                   c, output_z_stb, output_z, output_z_invalid);
        end
        checks++;
        if (input_a_ack !== 1'b0) begin
          errors++;
          $display("FAIL hold_in_ack cycle %0d: got %b want 0", c, input_a_ack);
        end
      end
      input_a_stb = 1'b0;
      ack_result();
      checks++;
      if (output_z_stb !== 1'b0) begin
        errors++;
        $display("FAIL hold_release: stb=%b want 0", output_z_stb);
      end
    end
    // Stray ack before any result is pending must be ignored.
    output_z_ack = 1'b1;
    repeat (3) @(posedge clk);
    #1 output_z_ack = 1'b0;
    run(32'h40400000, z, inv, lat, ok); // 3.0
    if (ok) begin
      checks++;
      if (z !== 32'h00000003 || inv !== 1'b0 || lat != 35) begin
        errors++;
        $display("FAIL after_stray_ack: z=%h inv=%b lat=%0d want 00000003 0 35", z, inv, lat);
      end
    end
  endtask

  task automatic test_reset_mid_shift();
    bit ok;
    int lat;
    logic [31:0] z;
    logic        inv;
    capture(32'h3F800000, ok);
    repeat (10) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    checks++;
    if (output_z_stb !== 1'b0 || input_a_ack !== 1'b0 || output_z !== 32'h0 || output_z_invalid !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: stb=%b ack=%b z=%h inv=%b want all 0",
               output_z_stb, input_a_ack, output_z, output_z_invalid);
    end
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    // The abandoned conversion must never surface.
    for (int c = 0; c < 40; c++) begin
      @(posedge clk);
      #1;
      if (output_z_stb) begin
        checks++;
        errors++;
        $display("FAIL ghost_result: stb=%b z=%h want no result", output_z_stb, output_z);
        break;
      end
    end
    run(32'hC0200000, z, inv, lat, ok);
    if (ok) begin
      checks++;
      if (z !== 32'hFFFFFFFE || inv !== 1'b0 || lat != 35) begin
        errors++;
        $display("FAIL post_reset: z=%h inv=%b lat=%0d want fffffffe 0 35", z, inv, lat);
      end
    end
  endtask

  initial begin
    checks       = 0;
    errors       = 0;
    rst          = 1'b1;
    input_a      = '0;
    input_a_stb  = 1'b0;
    output_z_ack = 1'b0;
    test_reset();
    test_vectors();
    test_backpressure();
    test_reset_mid_shift();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
